// File: rtl/instruction_memory_loadable_pkg.sv
// Shared constants and loader state type for the loadable instruction memory.
package im_pkg;

  localparam int unsigned IM_WORD_WIDTH  = 32;
  localparam int unsigned BYTES_PER_WORD = IM_WORD_WIDTH / 8;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instruction_memory_loadable_byte_assembler.sv
// Packs an MSB-first byte stream into words; word_valid is combinational so the
// word can be written on the same edge that accepts its last byte.
module im_byte_assembler #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int unsigned BPW   = WORD_WIDTH / 8;
  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_byte;

  assign last_byte  = (cnt_q == CNT_W'(BPW - 1));
  assign word       = WORD_WIDTH'({shift_q, byte_in});
  assign word_valid = byte_valid && last_byte;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (byte_valid) begin
      shift_d = word;
      cnt_d   = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Byte-loadable instruction RAM with a stallable registered fetch port.
// Optional debug read port enabled by defining IM_READBACK_EN.
module instruction_memory_loadable
  import im_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 9,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned DATA_LENGTH = WORD_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_start,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte,
  input  logic                   i_fetch_en,
  input  logic [ADDR_LENGTH-1:0] i_Addr,
  output logic [DATA_LENGTH-1:0] o_Data,
  output logic                   o_loading,
  output logic                   o_load_done,
  output logic                   o_overflow,
  output logic [MEM_SIZE:0]      o_word_count
`ifdef IM_READBACK_EN
  ,
  input  logic [MEM_SIZE-1:0]    i_dbg_addr,
  output logic [WORD_WIDTH-1:0]  o_dbg_data
`endif
);

  localparam int unsigned DEPTH = 1 << MEM_SIZE;
  localparam logic [MEM_SIZE-1:0] LAST_IDX = MEM_SIZE'(DEPTH - 1);

  load_state_e           state_q, state_d;
  logic [MEM_SIZE-1:0]   ptr_q, ptr_d;
  logic [MEM_SIZE:0]     count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0] data_q;

  logic [WORD_WIDTH-1:0] asm_word;
  logic                  asm_valid;
  logic                  is_halt;
  logic                  at_last;
  logic [MEM_SIZE-1:0]   fetch_idx;
  logic                  unused_addr_bits;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  assign fetch_idx        = i_Addr[MEM_SIZE+1:2];
  assign unused_addr_bits = ^{i_Addr[ADDR_LENGTH-1:MEM_SIZE+2], i_Addr[1:0]};

  // A restart drops any byte presented in the same cycle.
  im_byte_assembler #(.WORD_WIDTH(WORD_WIDTH)) u_asm (
    .clk        (i_clk),
    .clr        (i_reset | i_load_start),
    .byte_valid (i_byte_valid && (state_q == LOAD) && !i_load_start),
    .byte_in    (i_byte),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign is_halt = (asm_word == WORD_WIDTH'(HALT_WORD));
  assign at_last = (ptr_q == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (i_load_start) begin
      state_d    = LOAD;
      ptr_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (asm_valid) begin
      count_d = count_q + 1'b1;
      if (!at_last) begin
        ptr_d = ptr_q + 1'b1;
      end
      if (is_halt || at_last) begin
        state_d = DONE;
      end
      if (at_last && !is_halt) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    o_loading    = (state_q == LOAD);
    o_load_done  = (state_q == DONE);
    o_overflow   = overflow_q;
    o_word_count = count_q;
    o_Data       = DATA_LENGTH'(data_q);
  end

  always_ff @(posedge i_clk) begin
    if (asm_valid) begin
      mem[ptr_q] <= asm_word;
    end
  end

  // Fetch only reads the array in DONE, so it never collides with a write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= WORD_WIDTH'(NOP_WORD);
    end else if (i_fetch_en) begin
      data_q <= (state_q == DONE) ? mem[fetch_idx] : WORD_WIDTH'(NOP_WORD);
    end
  end

`ifdef IM_READBACK_EN
  logic [WORD_WIDTH-1:0] dbg_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= mem[i_dbg_addr];
    end
  end

  assign o_dbg_data = dbg_q;
`else
  // Without readback the fetch port is the array's only reader.
`endif

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable; one line per transaction.
module tb_instruction_memory_loadable;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_load_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_fetch_en;
  logic [31:0] i_Addr;
  logic [31:0] o_Data;
  logic        o_loading;
  logic        o_load_done;
  logic        o_overflow;
  logic [9:0]  o_word_count;
`ifdef IM_READBACK_EN
  logic [8:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  instruction_memory_loadable dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_start (i_load_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .i_fetch_en   (i_fetch_en),
    .i_Addr       (i_Addr),
    .o_Data       (o_Data),
    .o_loading    (o_loading),
    .o_load_done  (o_load_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
`ifdef IM_READBACK_EN
    ,
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data   (o_dbg_data)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] b, input logic bv);
    i_load_start = 1'b1;
    i_byte_valid = bv;
    i_byte       = b;
    tick();
    i_load_start = 1'b0;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1'b1;
    i_byte       = b;
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    i_fetch_en = 1'b1;
    i_Addr     = addr;
    tick();
    checks++;
    if (o_Data !== exp) begin
      errors++;
      $display("FAIL %s: o_Data=%h expected %h", name, o_Data, exp);
    end else begin
      $display("fetch %s addr=%h data=%h", name, addr, o_Data);
    end
  endtask

  task automatic check_flags(input string name, input logic ld, input logic dn,
                             input logic ov, input logic [9:0] cnt);
    checks++;
    if ({o_loading, o_load_done, o_overflow, o_word_count} !== {ld, dn, ov, cnt}) begin
      errors++;
      $display("FAIL %s: loading=%b done=%b ovf=%b count=%0d expected %b %b %b %0d",
               name, o_loading, o_load_done, o_overflow, o_word_count, ld, dn, ov, cnt);
    end else begin
      $display("flags %s loading=%b done=%b ovf=%b count=%0d",
               name, o_loading, o_load_done, o_overflow, o_word_count);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    check_flags("reset", 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (o_Data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: o_Data=%h expected 00000000", o_Data);
    end
    fetch(32'h0, 32'h0, "idle_nop");
  endtask

  task automatic test_basic_load();
    start_load(8'h00, 1'b0);
    check_flags("load_started", 1'b1, 1'b0, 1'b0, 10'd0);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    check_flags("two_words", 1'b1, 1'b0, 1'b0, 10'd2);
    send_word(32'hFFFF_FFFF);
    check_flags("halt_done", 1'b0, 1'b1, 1'b0, 10'd3);
    fetch(32'h0, 32'h1122_3344, "w0");
    fetch(32'h4, 32'hAABB_CCDD, "w1");
    fetch(32'h8, 32'hFFFF_FFFF, "w2");
    fetch(32'h0000_0806, 32'hAABB_CCDD, "ignored_bits");
  endtask

  task automatic test_stall_and_nop();
    i_fetch_en = 1'b0;
    i_Addr     = 32'h0;
    tick();
    tick();
    checks++;
    if (o_Data !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL stall_hold: o_Data=%h expected aabbccdd", o_Data);
    end else begin
      $display("stall hold data=%h", o_Data);
    end
    start_load(8'h00, 1'b0);
    check_flags("restart", 1'b1, 1'b0, 1'b0, 10'd0);
    fetch(32'h4, 32'h0, "load_nop");
  endtask

`ifdef IM_READBACK_EN
  task automatic test_readback();
    i_dbg_addr = 9'd1;
    tick();
    checks++;
    if (o_dbg_data !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL readback: o_dbg_data=%h expected aabbccdd", o_dbg_data);
    end else begin
      $display("readback addr=1 data=%h", o_dbg_data);
    end
  endtask
`endif

  task automatic test_overflow();
    i_fetch_en = 1'b0;
    start_load(8'h00, 1'b0);
    for (int w = 0; w < 512; w++) send_word(32'h5A00_0000 | w);
    check_flags("overflow", 1'b0, 1'b1, 1'b1, 10'd512);
    send_word(32'h1234_5678);
    check_flags("bytes_after_done", 1'b0, 1'b1, 1'b1, 10'd512);
    fetch(32'h0, 32'h5A00_0000, "ovf_idx0");
    fetch(32'h7FC, 32'h5A00_01FF, "ovf_idx511");
  endtask

  task automatic test_restart_mid_word();
    i_fetch_en = 1'b0;
    start_load(8'h00, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    start_load(8'hEE, 1'b1);
    check_flags("restart_clears", 1'b1, 1'b0, 1'b0, 10'd0);
    send_word(32'h0102_0304);
    send_word(32'hFFFF_FFFF);
    check_flags("restart_done", 1'b0, 1'b1, 1'b0, 10'd2);
    fetch(32'h0, 32'h0102_0304, "restart_w0");
  endtask

  task automatic test_reset_mid_load();
    i_fetch_en = 1'b0;
    start_load(8'h00, 1'b0);
    for (int b = 1; b <= 6; b++) send_byte(8'(b * 16));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_flags("reset_mid", 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (o_Data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_data: o_Data=%h expected 00000000", o_Data);
    end
    start_load(8'h00, 1'b0);
    send_word(32'h0BAD_F00D);
    send_word(32'hFFFF_FFFF);
    check_flags("reload_done", 1'b0, 1'b1, 1'b0, 10'd2);
    fetch(32'h0, 32'h0BAD_F00D, "reload_w0");
    fetch(32'h4, 32'hFFFF_FFFF, "reload_w1");
  endtask

  initial begin
    i_reset      = 1'b1;
    i_load_start = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    i_fetch_en   = 1'b0;
    i_Addr       = 32'h0;
`ifdef IM_READBACK_EN
    i_dbg_addr   = 9'd0;
`endif
    test_reset();
    test_basic_load();
    test_stall_and_nop();
`ifdef IM_READBACK_EN
    test_readback();
`endif
    test_overflow();
    test_restart_mid_word();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
